// File: rtl/fifo_thresh_if.sv
// fifo_thresh_if
// Bundles the enqueue/dequeue handshake and the status outputs of fifo_thresh.
//   master : producer/consumer side, drives enqueue, dequeue, flush and back,
//            and observes front, occupied and all status flags.
//   slave  : the FIFO itself.
// SIZE and DATA_WIDTH must match the parameters of the attached fifo_thresh.
interface fifo_thresh_if #(
  parameter int SIZE       = 16,
  parameter int DATA_WIDTH = 32
);
  localparam int CW = $clog2(SIZE) + 1;

  logic                  enqueue;
  logic                  dequeue;
  logic                  flush;
  logic [DATA_WIDTH-1:0] back;
  logic [DATA_WIDTH-1:0] front;
  logic [CW-1:0]         occupied;
  logic                  full;
  logic                  empty;
  logic                  almostFull;
  logic                  almostEmpty;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output enqueue, dequeue, flush, back,
    input  front, occupied, full, empty, almostFull, almostEmpty, overflow, underflow
  );

  modport slave (
    input  enqueue, dequeue, flush, back,
    output front, occupied, full, empty, almostFull, almostEmpty, overflow, underflow
  );
endinterface

// File: rtl/fifo_thresh.sv
// fifo_thresh
// Synchronous FIFO with occupancy count, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and a synchronous flush.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (same effect as flush, top priority)
//   bus  : fifo_thresh_if.slave carrying enqueue/dequeue/flush/back in and
//          front/occupied/full/empty/almostFull/almostEmpty/overflow/underflow out
// Storage is a dual-port RAM with a registered read port. The read address
// looks one entry ahead on a dequeue so front has no extra latency, and a
// bypass register covers the case where the slot being read is written in
// the same cycle (the RAM returns the old contents in that case).
module fifo_thresh #(
  parameter int SIZE       = 16,
  parameter int DATA_WIDTH = 32,
  parameter int AF_THRESH  = SIZE - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  fifo_thresh_if.slave      bus
);
  localparam int PW = $clog2(SIZE);
  localparam int CW = PW + 1;

  logic [DATA_WIDTH-1:0] mem [SIZE];
  logic [DATA_WIDTH-1:0] ram_q;
  logic [DATA_WIDTH-1:0] bypass_data;
  logic                  bypass_valid;
  logic [PW-1:0]         back_ptr;
  logic [PW-1:0]         front_ptr;
  logic [PW-1:0]         rd_addr;
  logic [CW-1:0]         occ;
  logic                  ovf;
  logic                  unf;
  logic                  is_full;
  logic                  is_empty;
  logic                  commit_enq;
  logic                  commit_deq;
  logic                  bypass_hit;

  // Pointers wrap by explicit compare so SIZE need not be a power of two.
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(SIZE - 1)) ? '0 : p + 1'b1;
  endfunction

  assign is_full    = (occ == CW'(SIZE));
  assign is_empty   = (occ == '0);
  assign commit_enq = bus.enqueue & ~is_full  & ~bus.flush;
  assign commit_deq = bus.dequeue & ~is_empty & ~bus.flush;
  assign rd_addr    = commit_deq ? wrap_inc(front_ptr) : front_ptr;
  assign bypass_hit = commit_enq & (back_ptr == rd_addr);

  // RAM: write on committed enqueue, registered read of the look-ahead head.
  always_ff @(posedge clk) begin
    if (commit_enq) begin
      mem[back_ptr] <= bus.back;
    end
    ram_q <= mem[rd_addr];
  end

  // Pointer, occupancy, bypass and sticky-flag state.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      back_ptr     <= '0;
      front_ptr    <= '0;
      occ          <= '0;
      bypass_valid <= 1'b0;
      bypass_data  <= '0;
      ovf          <= 1'b0;
      unf          <= 1'b0;
    end else begin
      if (commit_enq) begin
        back_ptr <= wrap_inc(back_ptr);
      end
      if (commit_deq) begin
        front_ptr <= rd_addr;
      end
      case ({commit_enq, commit_deq})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      // Re-evaluated every cycle: once the RAM has caught up the bypass drops.
      bypass_valid <= bypass_hit;
      if (bypass_hit) begin
        bypass_data <= bus.back;
      end
      if (bus.enqueue && is_full) begin
        ovf <= 1'b1;
      end
      if (bus.dequeue && is_empty) begin
        unf <= 1'b1;
      end
    end
  end

  assign bus.front       = is_empty ? '0 : (bypass_valid ? bypass_data : ram_q);
  assign bus.occupied    = occ;
  assign bus.full        = is_full;
  assign bus.empty       = is_empty;
  assign bus.almostFull  = (occ >= CW'(AF_THRESH));
  assign bus.almostEmpty = (occ <= CW'(AE_THRESH));
  assign bus.overflow    = ovf;
  assign bus.underflow   = unf;
endmodule

// File: tb/tb_fifo_thresh.sv
// tb_fifo_thresh
// Drives two fifo_thresh instances with identical stimulus:
//   dutA : SIZE=4, DATA_WIDTH=8, AF_THRESH=3, AE_THRESH=1
//   dutB : SIZE=5, DATA_WIDTH=8, AF_THRESH=3, AE_THRESH=2 (non power-of-two depth)
// Each instance is compared every cycle against a queue-based reference model;
// directed sequences also check hand-derived constants on dutA/dutB.
module tb_fifo_thresh;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fifo_thresh_if #(.SIZE(4), .DATA_WIDTH(8)) busA ();
  fifo_thresh_if #(.SIZE(5), .DATA_WIDTH(8)) busB ();

  fifo_thresh #(.SIZE(4), .DATA_WIDTH(8), .AF_THRESH(3), .AE_THRESH(1)) dutA (
    .clk (clk),
    .rst (rst),
    .bus (busA.slave)
  );

  fifo_thresh #(.SIZE(5), .DATA_WIDTH(8), .AF_THRESH(3), .AE_THRESH(2)) dutB (
    .clk (clk),
    .rst (rst),
    .bus (busB.slave)
  );

  int checkCount = 0;
  int failCount  = 0;

  logic [7:0] qA[$];
  logic [7:0] qB[$];
  bit ovfA, unfA, ovfB, unfB;

  // One comparison: count it, report a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Reference behaviour: a plain queue bounded at the FIFO depth.
  task automatic modelUpdate(input bit r, input bit e, input bit d, input bit f,
                             input logic [7:0] data);
    if (r || f) begin
      qA.delete();
      qB.delete();
      ovfA = 0; unfA = 0; ovfB = 0; unfB = 0;
    end else begin
      bit fullA, emptyA, fullB, emptyB;
      fullA  = (qA.size() == 4);
      emptyA = (qA.size() == 0);
      fullB  = (qB.size() == 5);
      emptyB = (qB.size() == 0);
      if (e && fullA)  ovfA = 1;
      if (d && emptyA) unfA = 1;
      if (e && fullB)  ovfB = 1;
      if (d && emptyB) unfB = 1;
      if (d && !emptyA) void'(qA.pop_front());
      if (e && !fullA)  qA.push_back(data);
      if (d && !emptyB) void'(qB.pop_front());
      if (e && !fullB)  qB.push_back(data);
    end
  endtask

  task automatic checkModel();
    int na;
    int nb;
    na = qA.size();
    nb = qB.size();
    checkOutput("A.front",       32'(busA.front),       (na != 0) ? 32'(qA[0]) : 32'd0);
    checkOutput("A.occupied",    32'(busA.occupied),    32'(na));
    checkOutput("A.full",        32'(busA.full),        32'(na == 4));
    checkOutput("A.empty",       32'(busA.empty),       32'(na == 0));
    checkOutput("A.almostFull",  32'(busA.almostFull),  32'(na >= 3));
    checkOutput("A.almostEmpty", 32'(busA.almostEmpty), 32'(na <= 1));
    checkOutput("A.overflow",    32'(busA.overflow),    32'(ovfA));
    checkOutput("A.underflow",   32'(busA.underflow),   32'(unfA));
    checkOutput("B.front",       32'(busB.front),       (nb != 0) ? 32'(qB[0]) : 32'd0);
    checkOutput("B.occupied",    32'(busB.occupied),    32'(nb));
    checkOutput("B.full",        32'(busB.full),        32'(nb == 5));
    checkOutput("B.empty",       32'(busB.empty),       32'(nb == 0));
    checkOutput("B.almostFull",  32'(busB.almostFull),  32'(nb >= 3));
    checkOutput("B.almostEmpty", 32'(busB.almostEmpty), 32'(nb <= 2));
    checkOutput("B.overflow",    32'(busB.overflow),    32'(ovfB));
    checkOutput("B.underflow",   32'(busB.underflow),   32'(unfB));
  endtask

  // Drive one cycle to both DUTs, advance the model at the edge, check #1 later.
  task automatic applyStimulus(input bit r, input bit e, input bit d, input bit f,
                               input logic [7:0] data);
    rst          = r;
    busA.enqueue = e;
    busA.dequeue = d;
    busA.flush   = f;
    busA.back    = data;
    busB.enqueue = e;
    busB.dequeue = d;
    busB.flush   = f;
    busB.back    = data;
    @(posedge clk);
    modelUpdate(r, e, d, f, data);
    #1;
    checkModel();
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".A.front"},       32'(busA.front),       32'd0);
    checkOutput({tag, ".A.occupied"},    32'(busA.occupied),    32'd0);
    checkOutput({tag, ".A.empty"},       32'(busA.empty),       32'd1);
    checkOutput({tag, ".A.full"},        32'(busA.full),        32'd0);
    checkOutput({tag, ".A.almostEmpty"}, 32'(busA.almostEmpty), 32'd1);
    checkOutput({tag, ".A.almostFull"},  32'(busA.almostFull),  32'd0);
    checkOutput({tag, ".A.overflow"},    32'(busA.overflow),    32'd0);
    checkOutput({tag, ".A.underflow"},   32'(busA.underflow),   32'd0);
    checkOutput({tag, ".B.occupied"},    32'(busB.occupied),    32'd0);
    checkOutput({tag, ".B.empty"},       32'(busB.empty),       32'd1);
  endtask

  initial begin
    logic [7:0] deqExp [4];
    deqExp[0] = 8'h22; deqExp[1] = 8'h33; deqExp[2] = 8'h44; deqExp[3] = 8'h00;

    // Reset
    applyStimulus(1, 0, 0, 0, 8'h00);
    applyStimulus(1, 0, 0, 0, 8'h00);
    checkResetValues("reset");

    // Fill with 0x11, 0x22, 0x33: thresholds move, head stays 0x11
    applyStimulus(0, 1, 0, 0, 8'h11);
    checkOutput("fill1.occupied",    32'(busA.occupied),    32'd1);
    checkOutput("fill1.almostEmpty", 32'(busA.almostEmpty), 32'd1);
    checkOutput("fill1.front",       32'(busA.front),       32'h11);
    applyStimulus(0, 1, 0, 0, 8'h22);
    checkOutput("fill2.occupied",    32'(busA.occupied),    32'd2);
    checkOutput("fill2.almostEmpty", 32'(busA.almostEmpty), 32'd0);
    checkOutput("fill2.almostFull",  32'(busA.almostFull),  32'd0);
    checkOutput("fill2.front",       32'(busA.front),       32'h11);
    applyStimulus(0, 1, 0, 0, 8'h33);
    checkOutput("fill3.occupied",    32'(busA.occupied),    32'd3);
    checkOutput("fill3.almostFull",  32'(busA.almostFull),  32'd1);
    checkOutput("fill3.front",       32'(busA.front),       32'h11);

    // 0x44 fills dutA, 0x55 is rejected and flagged
    applyStimulus(0, 1, 0, 0, 8'h44);
    checkOutput("fill4.full",        32'(busA.full),        32'd1);
    checkOutput("fill4.overflow",    32'(busA.overflow),    32'd0);
    applyStimulus(0, 1, 0, 0, 8'h55);
    checkOutput("over.occupied",     32'(busA.occupied),    32'd4);
    checkOutput("over.overflow",     32'(busA.overflow),    32'd1);
    checkOutput("over.B.full",       32'(busB.full),        32'd1);
    checkOutput("over.B.overflow",   32'(busB.overflow),    32'd0);

    // Drain dutA: back-to-back dequeues, no bubbles
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 1, 0, 8'h00);
      checkOutput($sformatf("drain%0d.front", i), 32'(busA.front), 32'(deqExp[i]));
      checkOutput($sformatf("drain%0d.overflow", i), 32'(busA.overflow), 32'd1);
    end
    checkOutput("drain.empty", 32'(busA.empty), 32'd1);

    // Empty + enqueue + dequeue together: enqueue wins, underflow sets
    applyStimulus(0, 1, 1, 0, 8'hA5);
    checkOutput("emptyBoth.occupied",  32'(busA.occupied),  32'd1);
    checkOutput("emptyBoth.front",     32'(busA.front),     32'hA5);
    checkOutput("emptyBoth.underflow", 32'(busA.underflow), 32'd1);

    // Refill dutA and hit full + enqueue + dequeue together
    applyStimulus(0, 1, 0, 0, 8'h01);
    applyStimulus(0, 1, 0, 0, 8'h02);
    applyStimulus(0, 1, 0, 0, 8'h03);
    checkOutput("refill.full", 32'(busA.full), 32'd1);
    applyStimulus(0, 1, 1, 0, 8'h99);
    checkOutput("fullBoth.occupied", 32'(busA.occupied), 32'd3);
    checkOutput("fullBoth.front",    32'(busA.front),    32'h01);
    checkOutput("fullBoth.overflow", 32'(busA.overflow), 32'd1);

    // Flush with enqueue in the same cycle; the enqueue is ignored
    applyStimulus(0, 1, 0, 1, 8'h66);
    checkOutput("flush.occupied",  32'(busA.occupied),  32'd0);
    checkOutput("flush.empty",     32'(busA.empty),     32'd1);
    checkOutput("flush.overflow",  32'(busA.overflow),  32'd0);
    checkOutput("flush.underflow", 32'(busA.underflow), 32'd0);
    checkOutput("flush.front",     32'(busA.front),     32'd0);
    checkOutput("flush.B.occupied", 32'(busB.occupied), 32'd0);
    applyStimulus(0, 1, 0, 0, 8'h7E);
    checkOutput("postFlush.front", 32'(busA.front), 32'h7E);

    // Steady traffic at occupancy 2 across pointer wrap
    applyStimulus(0, 1, 0, 0, 8'h80);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 1, 1, 0, 8'(8'h81 + i));
      checkOutput($sformatf("steady%0d.B.front", i), 32'(busB.front), 32'(8'(8'h80 + i)));
      checkOutput($sformatf("steady%0d.A.front", i), 32'(busA.front), 32'(8'(8'h80 + i)));
      checkOutput($sformatf("steady%0d.B.occ", i),   32'(busB.occupied), 32'd2);
    end

    // Reset in the middle of active traffic
    applyStimulus(0, 1, 0, 0, 8'hC1);
    applyStimulus(0, 1, 1, 0, 8'hC2);
    applyStimulus(1, 1, 1, 0, 8'hC3);
    checkResetValues("midRst");

    // Randomized traffic, enqueue-heavy then dequeue-heavy to reach both ends
    for (int i = 0; i < 600; i++) begin
      bit r, e, d, f;
      int enqPct;
      enqPct = ((i / 100) % 2 == 0) ? 75 : 30;
      r = ($urandom_range(79) == 0);
      f = ($urandom_range(39) == 0);
      e = ($urandom_range(99) < enqPct);
      d = ($urandom_range(99) < (100 - enqPct));
      applyStimulus(r, e, d, f, 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end
endmodule
